// File: rtl/fifo_stream_reader.sv
// Burst reader that drains an external zero-latency FIFO into a two-entry skid buffer
// and presents the words as a valid/ready stream.
module fifo_stream_reader #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DEPTH_LOG2 = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  fifo_read_enable,
    input  logic [WIDTH-1:0]      fifo_read_data,
    input  logic [DEPTH_LOG2:0]   burst_threshold,
    input  logic [DEPTH_LOG2:0]   burst_length,
    output logic                  stream_valid,
    input  logic                  stream_ready,
    output logic [WIDTH-1:0]      stream_data,
    output logic                  busy,
    output logic [15:0]           transfer_count
);

    localparam int unsigned LW = DEPTH_LOG2 + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] buf0_q, buf0_d;
    logic [WIDTH-1:0] buf1_q, buf1_d;
    logic [LW-1:0]    remaining_q, remaining_d;
    logic [15:0]      xfer_q, xfer_d;
    logic             push;
    logic             pop;

    // The read strobe never looks at stream_ready; buffer space alone gates it.
    assign fifo_read_enable = (state_q == S_BURST) && !fifo_empty && (count_q < 2'd2)
                              && !flush && !reset;
    assign push = fifo_read_enable;
    assign pop  = stream_valid && stream_ready && !flush && !reset;

    assign stream_valid   = (count_q != 2'd0);
    assign stream_data    = buf0_q;
    assign busy           = (state_q == S_BURST) || (count_q != 2'd0);
    assign transfer_count = xfer_q;

    // Skid buffer: buf0 is always the oldest entry.
    always_comb begin
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) buf0_d = fifo_read_data;
                    else                 buf1_d = fifo_read_data;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    buf0_d  = buf1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        buf0_d = fifo_read_data;
                    end else begin
                        buf0_d = buf1_q;
                        buf1_d = fifo_read_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Burst control; remaining only counts down when a finite burst length is set.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        if (flush) begin
            state_d     = S_IDLE;
            remaining_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty && (fifo_level >= burst_threshold)) begin
                        state_d     = S_BURST;
                        remaining_d = burst_length;
                    end
                end
                S_BURST: begin
                    if (push) begin
                        if (burst_length != '0) begin
                            if (remaining_q != '0) remaining_d = remaining_q - LW'(1);
                            if (remaining_q == LW'(1)) state_d = S_IDLE;
                        end
                    end else if (fifo_empty) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        xfer_d = xfer_q;
        if (pop) xfer_d = xfer_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            remaining_q <= '0;
            xfer_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            remaining_q <= remaining_d;
            xfer_q      <= xfer_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: models the attached FIFO and checks stream order.
module tb_fifo_stream_reader;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned DEPTH_LOG2 = 2;
    localparam int unsigned LW         = DEPTH_LOG2 + 1;

    logic                clock = 1'b0;
    logic                reset;
    logic                flush;
    logic                fifo_empty;
    logic [LW-1:0]       fifo_level;
    logic                fifo_read_enable;
    logic [WIDTH-1:0]    fifo_read_data;
    logic [LW-1:0]       burst_threshold;
    logic [LW-1:0]       burst_length;
    logic                stream_valid;
    logic                stream_ready;
    logic [WIDTH-1:0]    stream_data;
    logic                busy;
    logic [15:0]         transfer_count;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [15:0]      exp_xfer;
    logic             pop_pend;
    int               errors = 0;
    int               checks = 0;
    int               cyc    = 0;
    int               reads  = 0;

    always #5 clock = ~clock;

    fifo_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clock            (clock),
        .reset            (reset),
        .flush            (flush),
        .fifo_empty       (fifo_empty),
        .fifo_level       (fifo_level),
        .fifo_read_enable (fifo_read_enable),
        .fifo_read_data   (fifo_read_data),
        .burst_threshold  (burst_threshold),
        .burst_length     (burst_length),
        .stream_valid     (stream_valid),
        .stream_ready     (stream_ready),
        .stream_data      (stream_data),
        .busy             (busy),
        .transfer_count   (transfer_count)
    );

    task automatic drive_fifo();
        fifo_empty     = (fifo_q.size() == 0);
        fifo_level     = LW'(fifo_q.size());
        fifo_read_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic load(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        drive_fifo();
    endtask

    // One clock: scoreboard the handshake at negedge, then apply the FIFO pop after the edge.
    task automatic tick();
        logic [WIDTH-1:0] w;
        @(negedge clock);
        pop_pend = fifo_read_enable;
        if (!reset && !flush && stream_valid && stream_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got word %h, required none", stream_data);
            end else begin
                w = exp_q.pop_front();
                if (stream_data !== w) begin
                    errors++;
                    $display("FAIL sb_data: got %h, required %h", stream_data, w);
                end
            end
            exp_xfer++;
        end
        @(posedge clock);
        #1;
        cyc++;
        if (pop_pend) begin
            checks++;
            if (fifo_q.size() == 0) begin
                errors++;
                $display("FAIL read_empty: got read with level 0, required no read");
            end else begin
                fifo_q.delete(0);
            end
            reads++;
        end
        drive_fifo();
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (stream_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", stream_valid); end
        checks++; if (stream_data !== '0) begin errors++; $display("FAIL rst_data: got %h, required 00", stream_data); end
        checks++; if (fifo_read_enable !== 1'b0) begin errors++; $display("FAIL rst_rden: got %b, required 0", fifo_read_enable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
        checks++; if (transfer_count !== 16'h0000) begin errors++; $display("FAIL rst_xfer: got %h, required 0000", transfer_count); end
        reset = 1'b0;
        exp_xfer = 16'h0000;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b, required 0", busy); end
    endtask

    task automatic test_threshold();
        burst_threshold = LW'(3);
        burst_length    = LW'(0);
        stream_ready    = 1'b1;
        load(8'hA1); tick();
        load(8'hA2); tick(); tick();
        checks++; if (fifo_read_enable !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL thr_below: got rden=%b busy=%b, required 0 0", fifo_read_enable, busy); end
        checks++; if (fifo_q.size() != 2) begin errors++; $display("FAIL thr_no_read: got level %0d, required 2", fifo_q.size()); end
        load(8'hA3); tick();
        checks++; if (busy !== 1'b1 || fifo_read_enable !== 1'b1) begin errors++; $display("FAIL thr_start: got busy=%b rden=%b, required 1 1", busy, fifo_read_enable); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (stream_valid !== 1'b1) begin errors++; $display("FAIL thr_consec%0d: got valid %b, required 1", i, stream_valid); end
        end
        tick();
        checks++; if (busy !== 1'b0 || stream_valid !== 1'b0) begin errors++; $display("FAIL thr_end: got busy=%b valid=%b, required 0 0", busy, stream_valid); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL thr_drained: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_burst_length();
        bit ok;
        burst_threshold = LW'(1);
        burst_length    = LW'(2);
        stream_ready    = 1'b1;
        reads = 0;
        for (int i = 0; i < 4; i++) load(WIDTH'(8'hB0 + i));
        tick(); tick(); tick();
        checks++; if (reads != 2 || fifo_q.size() != 2) begin errors++; $display("FAIL len_reads: got reads=%0d level=%0d, required 2 2", reads, fifo_q.size()); end
        checks++; if (fifo_read_enable !== 1'b0) begin errors++; $display("FAIL len_idle: got rden %b, required 0", fifo_read_enable); end
        wait_drain(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL len_drain: got %0d pending, required 0", exp_q.size()); end
        tick(); tick();
        checks++; if (reads != 4 || busy !== 1'b0) begin errors++; $display("FAIL len_total: got reads=%0d busy=%b, required 4 0", reads, busy); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [WIDTH-1:0] held;
        burst_threshold = LW'(1);
        burst_length    = LW'(0);
        stream_ready    = 1'b0;
        reads = 0;
        for (int i = 0; i < 4; i++) load(WIDTH'(8'hC0 + i));
        repeat (6) tick();
        checks++; if (reads != 2 || fifo_read_enable !== 1'b0) begin errors++; $display("FAIL bp_stall: got reads=%0d rden=%b, required 2 0", reads, fifo_read_enable); end
        checks++; if (stream_valid !== 1'b1 || stream_data !== exp_q[0]) begin errors++; $display("FAIL bp_head: got valid=%b data=%h, required 1 %h", stream_valid, stream_data, exp_q[0]); end
        held = stream_data;
        repeat (3) tick();
        checks++; if (stream_data !== held || reads != 2) begin errors++; $display("FAIL bp_stable: got data=%h reads=%0d, required %h 2", stream_data, reads, held); end
        stream_ready = 1'b1;
        wait_drain(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size()); end
        tick(); tick();
        checks++; if (busy !== 1'b0 || fifo_q.size() != 0) begin errors++; $display("FAIL bp_end: got busy=%b level=%0d, required 0 0", busy, fifo_q.size()); end
    endtask

    task automatic test_flush();
        bit ok;
        int lvl;
        burst_threshold = LW'(1);
        burst_length    = LW'(0);
        stream_ready    = 1'b0;
        for (int i = 0; i < 4; i++) load(WIDTH'(8'hD0 + i));
        repeat (4) tick();
        lvl = fifo_q.size();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (stream_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fl_clear: got valid=%b busy=%b, required 0 0", stream_valid, busy); end
        checks++; if (transfer_count !== exp_xfer || fifo_q.size() != lvl) begin errors++; $display("FAIL fl_keep: got xfer=%h level=%0d, required %h %0d", transfer_count, fifo_q.size(), exp_xfer, lvl); end
        exp_q.delete(0);
        exp_q.delete(0);
        stream_ready = 1'b1;
        wait_drain(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fl_drain: got %0d pending, required 0", exp_q.size()); end
        repeat (3) tick();
        // Flush held in IDLE blocks the burst start.
        flush = 1'b1;
        load(8'hE0);
        tick(); tick();
        checks++; if (busy !== 1'b0 || fifo_q.size() != 1) begin errors++; $display("FAIL fl_hold: got busy=%b level=%0d, required 0 1", busy, fifo_q.size()); end
        flush = 1'b0;
        wait_drain(20, ok);
        repeat (3) tick();
        for (int i = 0; i < 4; i++) load(WIDTH'(8'hF0 + i));
        tick();
        checks++; if (fifo_read_enable !== 1'b1) begin errors++; $display("FAIL fl_pre: got rden %b, required 1", fifo_read_enable); end
        flush = 1'b1;
        #1;
        checks++; if (fifo_read_enable !== 1'b0) begin errors++; $display("FAIL fl_suppress: got rden %b, required 0", fifo_read_enable); end
        tick();
        flush = 1'b0;
        checks++; if (fifo_q.size() != 4) begin errors++; $display("FAIL fl_noread: got level %0d, required 4", fifo_q.size()); end
        wait_drain(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fl_drain2: got %0d pending, required 0", exp_q.size()); end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int lvl;
        burst_threshold = LW'(1);
        burst_length    = LW'(0);
        stream_ready    = 1'b1;
        for (int i = 0; i < 4; i++) load(WIDTH'(8'h60 + i));
        tick(); tick(); tick();
        reset = 1'b1;
        lvl = fifo_q.size();
        #1;
        checks++; if (fifo_read_enable !== 1'b0) begin errors++; $display("FAIL rm_rden: got %b, required 0", fifo_read_enable); end
        tick();
        checks++; if (stream_valid !== 1'b0 || stream_data !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rm_out: got valid=%b data=%h busy=%b, required 0 00 0", stream_valid, stream_data, busy); end
        checks++; if (transfer_count !== 16'h0000 || fifo_q.size() != lvl) begin errors++; $display("FAIL rm_keep: got xfer=%h level=%0d, required 0000 %0d", transfer_count, fifo_q.size(), lvl); end
        reset    = 1'b0;
        exp_q    = fifo_q;
        exp_xfer = 16'h0000;
        wait_drain(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rm_drain: got %0d pending, required 0", exp_q.size()); end
        repeat (3) tick();
    endtask

    task automatic test_wrap();
        bit ok;
        int fed   = 0;
        int start;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        exp_xfer = 16'h0000;
        drive_fifo();
        burst_threshold = LW'(1);
        burst_length    = LW'(0);
        stream_ready    = 1'b1;
        start = cyc;
        while ((fed < 65535 || exp_q.size() != 0) && (cyc - start) < 70000) begin
            if (fed < 65535 && fifo_q.size() < DEPTH) begin
                load(WIDTH'(fed));
                fed++;
            end
            tick();
        end
        checks++; if (fed != 65535 || exp_q.size() != 0) begin errors++; $display("FAIL wrap_timeout: got fed=%0d pending=%0d, required 65535 0", fed, exp_q.size()); end
        checks++; if ((cyc - start) > 65535 + 8) begin errors++; $display("FAIL wrap_rate: got %0d cycles, required <= %0d", cyc - start, 65535 + 8); end
        checks++; if (transfer_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h, required ffff", transfer_count); end
        load(8'h5A);
        wait_drain(20, ok);
        checks++; if (!ok || transfer_count !== 16'h0000) begin errors++; $display("FAIL wrap_0000: got %h, required 0000", transfer_count); end
        load(8'hA5);
        wait_drain(20, ok);
        checks++; if (!ok || transfer_count !== 16'h0001) begin errors++; $display("FAIL wrap_0001: got %h, required 0001", transfer_count); end
    endtask

    initial begin
        reset           = 1'b1;
        flush           = 1'b0;
        stream_ready    = 1'b0;
        burst_threshold = LW'(1);
        burst_length    = LW'(0);
        exp_xfer        = 16'h0000;
        pop_pend        = 1'b0;
        drive_fifo();
        test_reset();
        test_threshold();
        test_burst_length();
        test_backpressure();
        test_flush();
        test_reset_mid_burst();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
